// File: rtl/ez8_io_pkg.sv
// Shared definitions for the I/O-bus UART.
// Contents: register offsets, STATUS/CTRL bit indices, TX/RX FSM encodings,
//           and a divisor helper that maps 0 to 1.
package ez8_io_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;

  // Register offsets within the bank
  localparam logic [2:0] OFF_TXDATA = 3'd0;
  localparam logic [2:0] OFF_RXDATA = 3'd1;
  localparam logic [2:0] OFF_STATUS = 3'd2;
  localparam logic [2:0] OFF_CTRL   = 3'd3;
  localparam logic [2:0] OFF_DIVLO  = 3'd4;
  localparam logic [2:0] OFF_DIVHI  = 3'd5;

  // STATUS bit positions
  localparam int unsigned ST_TX_BUSY   = 0;
  localparam int unsigned ST_RX_AVAIL  = 1;
  localparam int unsigned ST_RX_FULL   = 2;
  localparam int unsigned ST_OVERRUN   = 3;
  localparam int unsigned ST_FRAME_ERR = 4;

  // CTRL bit positions
  localparam int unsigned CTRL_TX_IE = 0;
  localparam int unsigned CTRL_RX_IE = 1;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // A programmed divisor of 0 behaves as 1
  function automatic logic [DIV_W-1:0] div_eff(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/io_uart_fifo.sv
// RX byte FIFO for the UART.
// Ports: clk, reset_n (sync, active low), i_push/i_data, i_pop,
//        o_head (0 when empty), o_full, o_empty, o_drop_c (push lost to full).
module io_uart_fifo
  import ez8_io_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_drop_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_drop_c  = i_push & ~w_do_push;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage (no reset needed; guarded by count)
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/io_uart.sv
// 8N1 UART peripheral on the processor I/O bus.
// Ports: clk, reset_n (sync, active low), pause (freezes bus side),
//        io_readaddr/io_readdata (registered read), io_writeaddr/io_writedata/
//        io_write_en (write), uart_rx (async serial in), uart_tx (serial out),
//        irq[0] tx-ready, irq[1] rx-available (level, registered).
module io_uart
  import ez8_io_pkg::*;
#(
  parameter logic [1:0]  BANK        = 2'd0,
  parameter int unsigned RX_DEPTH    = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pause,
  input  logic [4:0]  io_readaddr,
  output logic [7:0]  io_readdata,
  input  logic [4:0]  io_writeaddr,
  input  logic [7:0]  io_writedata,
  input  logic        io_write_en,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [1:0]  irq
);

  // Bus-side registers
  logic [7:0]       r_readdata;
  logic [1:0]       r_ctrl;
  logic [7:0]       r_div_lo;
  logic [7:0]       r_div_hi;
  logic             r_overrun;
  logic             r_frame_err;
  logic [1:0]       r_irq;

  // TX engine
  tx_state_t        r_tx_state;
  logic             r_uart_tx;
  logic [7:0]       r_txdata;
  logic [7:0]       r_tx_shift;
  logic [DIV_W-1:0] r_tx_div;
  logic [DIV_W-1:0] r_tx_cnt;
  logic [2:0]       r_tx_idx;

  // RX engine
  rx_state_t        r_rx_state;
  logic             r_rx_s1;
  logic             r_rx_s2;
  logic             r_rx_prev;
  logic [7:0]       r_rx_shift;
  logic [DIV_W-1:0] r_rx_div;
  logic [DIV_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_idx;
  logic             r_rx_push;
  logic [7:0]       r_rx_byte;
  logic             r_frame_set;

  logic             w_wr_hit;
  logic [2:0]       w_wr_off;
  logic             w_tx_busy;
  logic             w_tx_start;
  logic [DIV_W-1:0] w_div_eff;
  logic [DIV_W:0]   w_div_p1;
  logic [DIV_W-1:0] w_rx_half_m1;
  logic             w_rx_fall;
  logic             w_pop;
  logic             w_clr_status;
  logic [7:0]       w_head;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic             w_drop;
  logic [7:0]       w_status;
  logic [7:0]       w_rd_data;

  assign w_wr_hit     = io_write_en & ~pause & (io_writeaddr[4:3] == BANK);
  assign w_wr_off     = io_writeaddr[2:0];
  assign w_tx_busy    = (r_tx_state != TX_IDLE);
  assign w_tx_start   = w_wr_hit & (w_wr_off == OFF_TXDATA) & ~w_tx_busy;
  assign w_pop        = w_wr_hit & (w_wr_off == OFF_RXDATA);
  assign w_clr_status = w_wr_hit & (w_wr_off == OFF_STATUS);
  assign w_div_eff    = div_eff({r_div_hi, r_div_lo});
  // Start-bit centre: (DIV+1)/2 cycles after the detected falling edge
  assign w_div_p1     = (DIV_W+1)'(w_div_eff) + (DIV_W+1)'(1);
  assign w_rx_half_m1 = DIV_W'(w_div_p1 >> 1) - DIV_W'(1);
  assign w_rx_fall    = r_rx_prev & ~r_rx_s2;

  assign w_status = {3'b000, r_frame_err, r_overrun, w_rx_full, ~w_rx_empty, w_tx_busy};

  assign io_readdata = r_readdata;
  assign uart_tx     = r_uart_tx;
  assign irq         = r_irq;

  io_uart_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_push   (r_rx_push),
    .i_data   (r_rx_byte),
    .i_pop    (w_pop),
    .o_head   (w_head),
    .o_full   (w_rx_full),
    .o_empty  (w_rx_empty),
    .o_drop_c (w_drop)
  );

  // Read mux; misses and unmapped offsets return 0
  always_comb begin
    w_rd_data = 8'h00;
    if (io_readaddr[4:3] == BANK) begin
      case (io_readaddr[2:0])
        OFF_TXDATA: w_rd_data = r_txdata;
        OFF_RXDATA: w_rd_data = w_head;
        OFF_STATUS: w_rd_data = w_status;
        OFF_CTRL:   w_rd_data = {6'b000000, r_ctrl};
        OFF_DIVLO:  w_rd_data = r_div_lo;
        OFF_DIVHI:  w_rd_data = r_div_hi;
        default:    w_rd_data = 8'h00;
      endcase
    end
  end

  // Bus registers, sticky status and interrupts
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_readdata  <= 8'h00;
      r_ctrl      <= 2'b00;
      r_div_lo    <= DEFAULT_DIV[7:0];
      r_div_hi    <= DEFAULT_DIV[15:8];
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 2'b00;
    end else begin
      if (!pause) r_readdata <= w_rd_data;
      if (w_wr_hit && w_wr_off == OFF_CTRL)  r_ctrl   <= io_writedata[1:0];
      if (w_wr_hit && w_wr_off == OFF_DIVLO) r_div_lo <= io_writedata;
      if (w_wr_hit && w_wr_off == OFF_DIVHI) r_div_hi <= io_writedata;
      // Write-1-to-clear; a same-cycle set wins
      r_overrun   <= w_drop |
                     (r_overrun & ~(w_clr_status & io_writedata[ST_OVERRUN]));
      r_frame_err <= r_frame_set |
                     (r_frame_err & ~(w_clr_status & io_writedata[ST_FRAME_ERR]));
      r_irq[0]    <= r_ctrl[CTRL_TX_IE] & ~w_tx_busy;
      r_irq[1]    <= r_ctrl[CTRL_RX_IE] & ~w_rx_empty;
    end
  end

  // TX FSM: start, 8 data bits LSB first, stop; divisor frozen per frame
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tx_state <= TX_IDLE;
      r_uart_tx  <= 1'b1;
      r_txdata   <= 8'h00;
      r_tx_shift <= 8'h00;
      r_tx_div   <= '0;
      r_tx_cnt   <= '0;
      r_tx_idx   <= 3'd0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_uart_tx <= 1'b1;
          if (w_tx_start) begin
            r_txdata   <= io_writedata;
            r_tx_shift <= io_writedata;
            r_tx_div   <= w_div_eff;
            r_tx_cnt   <= w_div_eff;
            r_uart_tx  <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt   <= r_tx_div;
            r_uart_tx  <= r_tx_shift[0];
            r_tx_idx   <= 3'd0;
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - DIV_W'(1);
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= r_tx_div;
            if (r_tx_idx == 3'd7) begin
              r_uart_tx  <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_uart_tx  <= r_tx_shift[1];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_idx   <= r_tx_idx + 3'd1;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - DIV_W'(1);
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == '0) r_tx_state <= TX_IDLE;
          else                r_tx_cnt   <= r_tx_cnt - DIV_W'(1);
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  // RX synchroniser and FSM; samples at bit centres
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_shift  <= 8'h00;
      r_rx_div    <= '0;
      r_rx_cnt    <= '0;
      r_rx_idx    <= 3'd0;
      r_rx_push   <= 1'b0;
      r_rx_byte   <= 8'h00;
      r_frame_set <= 1'b0;
    end else begin
      r_rx_s1     <= uart_rx;
      r_rx_s2     <= r_rx_s1;
      r_rx_prev   <= r_rx_s2;
      r_rx_push   <= 1'b0;
      r_frame_set <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_rx_fall) begin
            r_rx_div   <= w_div_eff;
            r_rx_cnt   <= w_rx_half_m1;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == '0) begin
            // High at the start-bit centre is a glitch: drop silently
            if (r_rx_s2) begin
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_cnt   <= r_rx_div;
              r_rx_idx   <= 3'd0;
              r_rx_state <= RX_DATA;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - DIV_W'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_cnt   <= r_rx_div;
            if (r_rx_idx == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_idx   <= r_rx_idx + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt - DIV_W'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == '0) begin
            if (r_rx_s2) begin
              r_rx_push <= 1'b1;
              r_rx_byte <= r_rx_shift;
            end else begin
              r_frame_set <= 1'b1;
            end
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt - DIV_W'(1);
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Scoreboard bench for io_uart: stimulus pushes expected read data and
// expected uart_tx line values; monitors pop and compare after each edge.
module tb_io_uart;

  logic       clk;
  logic       reset_n;
  logic       pause;
  logic [4:0] io_readaddr;
  logic [7:0] io_readdata;
  logic [4:0] io_writeaddr;
  logic [7:0] io_writedata;
  logic       io_write_en;
  logic       uart_rx;
  logic       uart_tx;
  logic [1:0] irq;

  io_uart #(.BANK(2'd0), .RX_DEPTH(4), .DEFAULT_DIV(16'd433)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pause        (pause),
    .io_readaddr  (io_readaddr),
    .io_readdata  (io_readdata),
    .io_writeaddr (io_writeaddr),
    .io_writedata (io_writedata),
    .io_write_en  (io_write_en),
    .uart_rx      (uart_rx),
    .uart_tx      (uart_tx),
    .irq          (irq)
  );

  localparam logic [2:0] O_TX = 3'd0, O_RX = 3'd1, O_ST = 3'd2, O_CT = 3'd3,
                         O_DL = 3'd4, O_DH = 3'd5;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rd_exp_q[$];
  string      rd_name_q[$];
  logic       line_exp_q[$];
  logic       rd_issue = 1'b0;
  logic       tx_run   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: read data is valid the edge after a read is presented
  always @(posedge clk) begin
    #1;
    if (rd_issue) begin
      if (rd_exp_q.size() == 0) begin
        chk("rd_unexpected", io_readdata, 8'hxx);
      end else begin
        chk(rd_name_q.pop_front(), io_readdata, rd_exp_q.pop_front());
      end
    end
    if (tx_run && line_exp_q.size() > 0) begin
      chk("uart_tx_line", {7'b0, uart_tx}, {7'b0, line_exp_q.pop_front()});
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_wr(input logic [2:0] off, input logic [7:0] d);
    io_writeaddr = {2'b00, off};
    io_writedata = d;
    io_write_en  = 1'b1;
    @(negedge clk);
    io_write_en  = 1'b0;
  endtask

  task automatic bus_rd_a(input logic [4:0] a, input logic [7:0] exp, input string name);
    io_readaddr = a;
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] off, input logic [7:0] exp, input string name);
    bus_rd_a({2'b00, off}, exp, name);
  endtask

  task automatic push_line(input logic v, input int n);
    for (int i = 0; i < n; i++) line_exp_q.push_back(v);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int div);
    uart_rx = 1'b0;
    repeat (div + 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (div + 1) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (div + 1) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  initial begin
    logic [7:0] tx_byte;
    logic [7:0] rx_bytes [5];
    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
    rx_bytes[3] = 8'h44; rx_bytes[4] = 8'h55;

    reset_n = 1'b0; pause = 1'b0; uart_rx = 1'b1;
    io_readaddr = 5'd0; io_writeaddr = 5'd0; io_writedata = 8'h00; io_write_en = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Reset state
    chk("rst_readdata", io_readdata, 8'h00);
    chk("rst_uart_tx", {7'b0, uart_tx}, 8'h01);
    chk("rst_irq", {6'b0, irq}, 8'h00);
    bus_rd(O_TX, 8'h00, "rst_txdata");
    bus_rd(O_RX, 8'h00, "rst_rxdata");
    bus_rd(O_ST, 8'h00, "rst_status");
    bus_rd(O_CT, 8'h00, "rst_ctrl");
    bus_rd(O_DL, 8'hB1, "rst_divlo");
    bus_rd(O_DH, 8'h01, "rst_divhi");
    bus_rd(3'd6, 8'h00, "rst_off6");
    bus_rd_a(5'b01_100, 8'h00, "other_bank_read");

    // TX frame at DIV=3
    bus_wr(O_DL, 8'h03);
    bus_wr(O_DH, 8'h00);
    bus_wr(O_CT, 8'h01);
    tick();
    chk("irq_tx_idle", {6'b0, irq}, 8'h01);
    tx_byte = 8'hA5;
    push_line(1'b0, 4);
    for (int i = 0; i < 8; i++) push_line(tx_byte[i], 4);
    push_line(1'b1, 14);
    io_writeaddr = {2'b00, O_TX}; io_writedata = 8'hA5; io_write_en = 1'b1;
    tx_run = 1'b1;
    tick();
    io_write_en = 1'b0;
    repeat (8) tick();
    bus_wr(O_TX, 8'h5A);
    chk("irq_tx_busy", {6'b0, irq}, 8'h00);
    bus_rd(O_ST, 8'h01, "status_tx_busy");
    bus_rd(O_TX, 8'hA5, "txdata_after_drop");
    repeat (45) tick();
    chk("irq_tx_done", {6'b0, irq}, 8'h01);
    bus_rd(O_ST, 8'h00, "status_tx_idle");

    // RX byte 3C at DIV=7
    bus_wr(O_DL, 8'h07);
    bus_wr(O_CT, 8'h02);
    send_rx(8'h3C, 1'b1, 7);
    repeat (10) tick();
    bus_rd(O_ST, 8'h02, "status_rx_avail");
    bus_rd(O_RX, 8'h3C, "rxdata_3c");
    chk("irq_rx_avail", {6'b0, irq}, 8'h02);
    bus_wr(O_RX, 8'h00);
    bus_rd(O_ST, 8'h00, "status_after_pop");
    chk("irq_rx_empty", {6'b0, irq}, 8'h00);

    // Overrun: RX_DEPTH+1 bytes unread
    for (int i = 0; i < 5; i++) send_rx(rx_bytes[i], 1'b1, 7);
    repeat (10) tick();
    bus_rd(O_ST, 8'h0E, "status_overrun");
    bus_rd(O_RX, 8'h11, "head_first_byte");
    bus_wr(O_ST, 8'h08);
    bus_rd(O_ST, 8'h06, "status_overrun_clr");
    for (int i = 1; i < 4; i++) begin
      bus_wr(O_RX, 8'hFF);
      bus_rd(O_RX, rx_bytes[i], "drain_head");
    end
    bus_wr(O_RX, 8'hFF);
    bus_wr(O_RX, 8'hFF);
    bus_rd(O_ST, 8'h00, "status_drained");
    bus_rd(O_RX, 8'h00, "rxdata_empty");

    // Start-bit glitch
    uart_rx = 1'b0;
    repeat (2) tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    bus_rd(O_ST, 8'h00, "status_glitch");

    // Framing error
    send_rx(8'h77, 1'b0, 7);
    repeat (10) tick();
    bus_rd(O_ST, 8'h10, "status_frame_err");
    bus_rd(O_RX, 8'h00, "rxdata_after_ferr");
    bus_wr(O_ST, 8'h10);
    bus_rd(O_ST, 8'h00, "status_ferr_clr");

    // Pause freezes the bus side; RX keeps running
    fork
      send_rx(8'h5E, 1'b1, 7);
      begin
        repeat (5) tick();
        bus_rd(O_DL, 8'h07, "divlo_before_pause");
        pause = 1'b1;
        bus_wr(O_TX, 8'hC3);
        bus_rd(O_CT, 8'h07, "readdata_held");
        bus_rd(O_ST, 8'h07, "readdata_held2");
        tick();
        chk("tx_quiet_paused", {7'b0, uart_tx}, 8'h01);
      end
    join
    repeat (10) tick();
    pause = 1'b0;
    bus_rd(O_ST, 8'h02, "status_after_pause");
    bus_rd(O_RX, 8'h5E, "rx_during_pause");
    bus_rd(O_TX, 8'hA5, "txdata_unchanged");

    tick();
    chk("rd_queue_empty", 8'(rd_exp_q.size()), 8'h00);
    chk("line_queue_empty", 8'(line_exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
